// File: rtl/uart_pkg.sv
// Shared types and legal-range constants for the parameterised UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int DATA_BITS_MIN  = 5;
   localparam int DATA_BITS_MAX  = 8;
   localparam int FIFO_DEPTH_MIN = 2;
   localparam int FIFO_DEPTH_MAX = 256;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} tx_state_t;
`endif

   function automatic bit isPow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; storage is not reset, only the pointers.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [AW:0]      o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_pushOk;
   logic             w_popOk;

   assign w_pushOk = i_push && !o_full;
   assign w_popOk  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_data;
      end
   end

   // Pointers wrap modulo 2*DEPTH so full and empty can be told apart.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_popOk)  r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign o_empty = (r_wrPtr == r_rdPtr);
   assign o_count = r_wrPtr - r_rdPtr;
   assign o_data  = r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with TX FIFO, CTS flow control and optional stop2.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
   localparam int BIT_W     = $clog2(DATA_BITS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [DIV_W-1:0]     i_baud_div,
   input  logic                 i_stop2,
   input  logic                 i_parity_odd,
   input  logic                 i_cts_n,
   output logic                 o_txd,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_fifo_count,
   output logic                 o_empty_int
);

   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_badDataBits
      $error("uart_tx_param: DATA_BITS out of legal range");
   end
   if (!isPow2(FIFO_DEPTH) || FIFO_DEPTH < FIFO_DEPTH_MIN || FIFO_DEPTH > FIFO_DEPTH_MAX) begin : g_badDepth
      $error("uart_tx_param: FIFO_DEPTH must be a power of two in range");
   end

   tx_state_t            r_state;
   logic [1:0]           r_cts;
   logic [DIV_W-1:0]     r_div;
   logic [DIV_W-1:0]     r_baudCnt;
   logic [BIT_W-1:0]     r_bitCnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_stop2;
   logic                 r_txd;
   logic                 r_emptyInt;
   logic [DATA_BITS-1:0] w_fifoData;
   logic                 w_fifoFull;
   logic                 w_fifoEmpty;
   logic                 w_bitDone;
   logic                 w_lastStop;
   logic                 w_startFrame;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`else
   logic                 w_unusedParity;
   assign w_unusedParity = i_parity_odd;
`endif

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_valid),
      .i_data  (i_data),
      .i_pop   (w_startFrame),
      .o_data  (w_fifoData),
      .o_count (o_fifo_count),
      .o_full  (w_fifoFull),
      .o_empty (w_fifoEmpty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_cts <= 2'b11;
      else          r_cts <= {r_cts[0], i_cts_n};
   end

   // A new frame may start from IDLE or straight out of the final stop bit.
   assign w_bitDone    = (r_baudCnt == r_div - DIV_W'(1));
   assign w_lastStop   = w_bitDone && (((r_state == STOP1) && !r_stop2) || (r_state == STOP2));
   assign w_startFrame = !w_fifoEmpty && !r_cts[1] && ((r_state == IDLE) || w_lastStop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_txd      <= 1'b1;
         r_emptyInt <= 1'b0;
         r_div      <= DIV_W'(1);
         r_baudCnt  <= '0;
         r_bitCnt   <= '0;
         r_shift    <= '0;
         r_stop2    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_emptyInt <= 1'b0;
         if (r_state != IDLE) r_baudCnt <= w_bitDone ? '0 : r_baudCnt + 1'b1;
         if (w_startFrame) begin
            r_state   <= START;
            r_txd     <= 1'b0;
            r_shift   <= w_fifoData;
            r_div     <= (i_baud_div == '0) ? DIV_W'(1) : i_baud_div;
            r_stop2   <= i_stop2;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= (^w_fifoData) ^ i_parity_odd;
`endif
         end else if (w_bitDone) begin
            case (r_state)
               START: begin
                  r_state <= DATA;
                  r_txd   <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
               DATA: begin
                  if (r_bitCnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
                     r_txd   <= r_parity;
`else
                     r_state <= STOP1;
                     r_txd   <= 1'b1;
`endif
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                     r_txd    <= r_shift[0];
                     r_shift  <= r_shift >> 1;
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  r_state <= STOP1;
                  r_txd   <= 1'b1;
               end
`endif
               STOP1: begin
                  r_txd <= 1'b1;
                  if (r_stop2) begin
                     r_state <= STOP2;
                  end else begin
                     r_state    <= IDLE;
                     r_emptyInt <= w_fifoEmpty;
                  end
               end
               STOP2: begin
                  r_txd      <= 1'b1;
                  r_state    <= IDLE;
                  r_emptyInt <= w_fifoEmpty;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_txd       = r_txd;
   assign o_busy      = (r_state != IDLE);
   assign o_empty_int = r_emptyInt;
   assign o_ready     = !w_fifoFull;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (DATA_BITS=8, FIFO_DEPTH=4).
// Expected frames follow UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_tx_param;

   localparam int DATA_BITS  = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int DIV_W      = 16;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [DATA_BITS-1:0] i_data = '0;
   logic                 i_valid = 1'b0;
   logic [DIV_W-1:0]     i_baud_div = 16'd4;
   logic                 i_stop2 = 1'b0;
   logic                 i_parity_odd = 1'b1;
   logic                 i_cts_n = 1'b0;
   logic                 o_ready;
   logic                 o_txd;
   logic                 o_busy;
   logic [CNT_W-1:0]     o_fifo_count;
   logic                 o_empty_int;

   int checks = 0;
   int errors = 0;
   int emptyPulses = 0;

   uart_tx_param #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_baud_div   (i_baud_div),
      .i_stop2      (i_stop2),
      .i_parity_odd (i_parity_odd),
      .i_cts_n      (i_cts_n),
      .o_txd        (o_txd),
      .o_busy       (o_busy),
      .o_fifo_count (o_fifo_count),
      .o_empty_int  (o_empty_int)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (o_empty_int === 1'b1) emptyPulses++;

   // Push one byte; called at a negedge, returns at the next negedge with i_valid low.
   task automatic applyStimulus(input logic [7:0] d);
      i_data  = d;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   // Checks one frame cycle by cycle. immediate=1: the start bit must begin at the next negedge.
   task automatic checkFrame(input logic [7:0] d, input int div, input bit stop2,
                             input bit immediate, input string name);
      logic expBits[$];
      int   waitCnt;
      bit   bitOk;
      bit   busyOk;
      expBits.push_back(1'b0);
      for (int i = 0; i < 8; i++) expBits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      expBits.push_back((^d) ^ i_parity_odd);
`endif
      expBits.push_back(1'b1);
      if (stop2) expBits.push_back(1'b1);
      checks++;
      if (immediate) begin
         @(negedge clk);
         if (o_txd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s start: txd=%b required 0", name, o_txd);
         end
      end else begin
         waitCnt = 0;
         while (o_txd !== 1'b0 && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
         end
         if (o_txd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s start timeout: txd=%b required 0", name, o_txd);
            return;
         end
      end
      busyOk = 1'b1;
      for (int i = 0; i < expBits.size(); i++) begin
         bitOk = 1'b1;
         for (int c = 0; c < div; c++) begin
            if (!(i == 0 && c == 0)) @(negedge clk);
            if (o_txd !== expBits[i]) bitOk = 1'b0;
            if (o_busy !== 1'b1) busyOk = 1'b0;
         end
         checks++;
         if (!bitOk) begin
            errors++;
            $display("[TB] FAIL %s bit%0d: txd=%b required %b", name, i, o_txd, expBits[i]);
         end
      end
      checks++;
      if (!busyOk) begin
         errors++;
         $display("[TB] FAIL %s busy: busy dropped during frame, required 1", name);
      end
   endtask

   // Counts any cycle with txd low or busy high over a window; returns via output.
   task automatic watchIdle(input int cycles, output int badCycles);
      badCycles = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (o_txd !== 1'b1 || o_busy !== 1'b0) badCycles++;
      end
   endtask

   task automatic test_reset;
      int bad;
      #12;
      checks += 5;
      if (o_txd !== 1'b1)        begin errors++; $display("[TB] FAIL rst_txd: %b required 1", o_txd); end
      if (o_busy !== 1'b0)       begin errors++; $display("[TB] FAIL rst_busy: %b required 0", o_busy); end
      if (o_empty_int !== 1'b0)  begin errors++; $display("[TB] FAIL rst_int: %b required 0", o_empty_int); end
      if (o_fifo_count !== '0)   begin errors++; $display("[TB] FAIL rst_count: %0d required 0", o_fifo_count); end
      if (o_ready !== 1'b1)      begin errors++; $display("[TB] FAIL rst_ready: %b required 1", o_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      watchIdle(10, bad);
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL rst_release: %0d bad cycles required 0", bad); end
   endtask

   task automatic test_single_frame;
      int base;
      base = emptyPulses;
      i_baud_div = 16'd4;
      applyStimulus(8'hA5);
      checks += 3;
      if (o_fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL single_count: %0d required 1", o_fifo_count); end
      if (o_txd !== 1'b1)        begin errors++; $display("[TB] FAIL single_pre_txd: %b required 1", o_txd); end
      if (o_busy !== 1'b0)       begin errors++; $display("[TB] FAIL single_pre_busy: %b required 0", o_busy); end
      checkFrame(8'hA5, 4, 1'b0, 1'b1, "single");
      @(negedge clk);
      checks += 2;
      if (o_busy !== 1'b0)      begin errors++; $display("[TB] FAIL single_post_busy: %b required 0", o_busy); end
      if (o_empty_int !== 1'b1) begin errors++; $display("[TB] FAIL single_int: %b required 1", o_empty_int); end
      @(negedge clk);
      checks++;
      if (o_empty_int !== 1'b0) begin errors++; $display("[TB] FAIL single_int_width: %b required 0", o_empty_int); end
      repeat (3) @(negedge clk);
      checks++;
      if (emptyPulses - base != 1) begin
         errors++;
         $display("[TB] FAIL single_int_count: %0d required 1", emptyPulses - base);
      end
   endtask

   task automatic test_stop2_parity;
      i_baud_div = 16'd3;
      i_stop2    = 1'b1;
      applyStimulus(8'h03);
      checkFrame(8'h03, 3, 1'b1, 1'b1, "stop2");
      i_stop2 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_full_fifo;
      int bad;
      i_cts_n    = 1'b1;
      i_baud_div = 16'd2;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         i_data  = 8'h10 + 8'(i);
         i_valid = 1'b1;
         @(negedge clk);
      end
      checks += 2;
      if (o_ready !== 1'b0)      begin errors++; $display("[TB] FAIL full_ready: %b required 0", o_ready); end
      if (o_fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: %0d required 4", o_fifo_count); end
      i_data = 8'h55;
      @(negedge clk);
      i_valid = 1'b0;
      checks += 2;
      if (o_fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_ignore: %0d required 4", o_fifo_count); end
      if (o_busy !== 1'b0)       begin errors++; $display("[TB] FAIL full_cts_hold: busy=%b required 0", o_busy); end
      i_cts_n = 1'b0;
      checkFrame(8'h10, 2, 1'b0, 1'b0, "full0");
      for (int i = 1; i < 4; i++) checkFrame(8'h10 + 8'(i), 2, 1'b0, 1'b1, $sformatf("full%0d", i));
      watchIdle(40, bad);
      checks += 2;
      if (bad != 0) begin errors++; $display("[TB] FAIL full_no5th: %0d bad cycles required 0", bad); end
      if (o_fifo_count !== '0) begin errors++; $display("[TB] FAIL full_drain: %0d required 0", o_fifo_count); end
   endtask

   task automatic test_flow_control;
      int bad;
      int lowSeen;
      i_baud_div = 16'd4;
      i_data  = 8'h3C;
      i_valid = 1'b1;
      @(negedge clk);
      i_data = 8'hC3;
      @(negedge clk);
      i_valid = 1'b0;
      fork
         checkFrame(8'h3C, 4, 1'b0, 1'b0, "flow0");
         begin
            repeat (13) @(negedge clk);
            i_cts_n = 1'b1;
         end
      join
      watchIdle(30, bad);
      checks += 2;
      if (bad != 0) begin errors++; $display("[TB] FAIL flow_hold: %0d bad cycles required 0", bad); end
      if (o_fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL flow_count: %0d required 1", o_fifo_count); end
      i_cts_n = 1'b0;
      lowSeen = 0;
      repeat (2) begin
         @(negedge clk);
         if (o_txd !== 1'b1) lowSeen++;
      end
      checks++;
      if (lowSeen != 0) begin errors++; $display("[TB] FAIL flow_latency: %0d early low cycles required 0", lowSeen); end
      checkFrame(8'hC3, 4, 1'b0, 1'b1, "flow1");
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame;
      int bad;
      i_baud_div = 16'd4;
      applyStimulus(8'h00);
      applyStimulus(8'h77);
      repeat (10) @(negedge clk);
      checks++;
      if (o_txd !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pre: txd=%b required 0", o_txd); end
      #2 rst_n = 1'b0;
      #1;
      checks += 4;
      if (o_txd !== 1'b1)      begin errors++; $display("[TB] FAIL midrst_txd: %b required 1", o_txd); end
      if (o_fifo_count !== '0) begin errors++; $display("[TB] FAIL midrst_count: %0d required 0", o_fifo_count); end
      if (o_busy !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_busy: %b required 0", o_busy); end
      if (o_ready !== 1'b1)    begin errors++; $display("[TB] FAIL midrst_ready: %b required 1", o_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      watchIdle(30, bad);
      checks += 2;
      if (bad != 0) begin errors++; $display("[TB] FAIL midrst_release: %0d bad cycles required 0", bad); end
      if (o_fifo_count !== '0) begin errors++; $display("[TB] FAIL midrst_after: %0d required 0", o_fifo_count); end
   endtask

   task automatic test_back_to_back;
      int n;
      int guard;
      i_baud_div = 16'd2;
      n = 0;
      fork
         begin
            guard = 0;
            while (n < 10 && guard < 2000) begin
               if (o_ready === 1'b1) begin
                  i_data  = 8'(n);
                  i_valid = 1'b1;
                  n++;
               end else begin
                  i_valid = 1'b0;
               end
               @(negedge clk);
               guard++;
            end
            i_valid = 1'b0;
         end
         begin
            checkFrame(8'h00, 2, 1'b0, 1'b0, "wrap0");
            for (int i = 1; i < 10; i++) checkFrame(8'(i), 2, 1'b0, 1'b1, $sformatf("wrap%0d", i));
         end
      join
      repeat (3) @(negedge clk);
      checks += 2;
      if (n != 10) begin errors++; $display("[TB] FAIL wrap_pushes: %0d required 10", n); end
      if (o_fifo_count !== '0) begin errors++; $display("[TB] FAIL wrap_drain: %0d required 0", o_fifo_count); end
   endtask

   initial begin
      $display("[TB] uart_tx_param directed bench");
      test_reset();
      repeat (3) @(negedge clk);
      test_single_frame();
      test_stop2_parity();
      test_full_fifo();
      test_flow_control();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
